// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of an external dual-port RAM with a registered read port.
// A 2-entry output buffer gives first-word-fall-through data and keeps streaming bubble-free.
module ram_fifo_ctrl #(
  parameter int CAddrLen = 8,
  parameter int CDataLen = 16
) (
  input  logic                AClkH,
  input  logic                AResetH,
  input  logic                AClkHEn,
  input  logic [CDataLen-1:0] AWrData,
  input  logic                AWrStrobe,
  output logic                AFull,
  output logic [CDataLen-1:0] ARdData,
  output logic                ARdValid,
  input  logic                ARdAck,
  output logic [CAddrLen-1:0] ARamWrAddr,
  output logic [CDataLen-1:0] ARamWrData,
  output logic                ARamWrEn,
  output logic [CAddrLen-1:0] ARamRdAddr,
  output logic                ARamRdEn,
  input  logic [CDataLen-1:0] ARamRdData,
  output logic [CAddrLen+1:0] ACount,
  output logic                AOvf
);

  localparam logic [CAddrLen:0] CDepth = {1'b1, {CAddrLen{1'b0}}};

  logic [CAddrLen-1:0] wrPtr;
  logic [CAddrLen-1:0] rdPtr;
  logic [CAddrLen:0]   memCnt;
  logic                inFlight;
  logic [1:0]          bufCnt;
  logic [CDataLen-1:0] bufHead;
  logic [CDataLen-1:0] bufTail;

  logic       push;
  logic       pop;
  logic       issue;
  logic       capture;
  logic       captureToHead;
  logic [1:0] occupancy;

  // Every strobe is masked by reset so nothing reaches the RAM during reset cycles.
  always_comb begin
    push          = AClkHEn & ~AResetH & AWrStrobe & ~AFull;
    pop           = AClkHEn & ~AResetH & ARdAck & ARdValid;
    capture       = AClkHEn & ~AResetH & inFlight;
    occupancy     = bufCnt + 2'(inFlight) - 2'(pop);
    issue         = AClkHEn & ~AResetH & (memCnt != '0) & (occupancy < 2'd2);
    captureToHead = (bufCnt == 2'd0) || ((bufCnt == 2'd1) && pop);
  end

  assign AFull      = (memCnt == CDepth);
  assign ARamWrEn   = push;
  assign ARamWrAddr = wrPtr;
  assign ARamWrData = AWrData;
  assign ARamRdEn   = issue;
  assign ARamRdAddr = rdPtr;
  assign ARdValid   = (bufCnt != 2'd0);
  assign ARdData    = ARdValid ? bufHead : '0;
  assign ACount     = (CAddrLen+2)'(memCnt) + (CAddrLen+2)'(inFlight) + (CAddrLen+2)'(bufCnt);

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      memCnt   <= '0;
      inFlight <= 1'b0;
      bufCnt   <= 2'd0;
      AOvf     <= 1'b0;
    end else if (AClkHEn) begin
      if (push)  wrPtr <= wrPtr + CAddrLen'(1);
      if (issue) rdPtr <= rdPtr + CAddrLen'(1);
      memCnt   <= memCnt + (CAddrLen+1)'(push) - (CAddrLen+1)'(issue);
      inFlight <= issue;
      bufCnt   <= bufCnt + 2'(capture) - 2'(pop);
      if (AWrStrobe && AFull) AOvf <= 1'b1;
    end
  end

  // NOTE: the buffer payload is deliberately not reset; bufCnt qualifies it and
  // ARdData is forced to zero whenever the buffer is empty.
  always_ff @(posedge AClkH) begin
    if (pop) bufHead <= bufTail;
    if (capture) begin
      if (captureToHead) bufHead <= ARamRdData;
      else               bufTail <= ARamRdData;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: behavioural RAM plus a queue-based reference
// model of the FIFO contents; randomized data and handshakes.
module tb_ram_fifo_ctrl;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          AClkH = 1'b0;
  logic          AResetH = 1'b1;
  logic          AClkHEn = 1'b0;
  logic [DW-1:0] AWrData = '0;
  logic          AWrStrobe = 1'b0;
  logic          AFull;
  logic [DW-1:0] ARdData;
  logic          ARdValid;
  logic          ARdAck = 1'b0;
  logic [AW-1:0] ARamWrAddr;
  logic [DW-1:0] ARamWrData;
  logic          ARamWrEn;
  logic [AW-1:0] ARamRdAddr;
  logic          ARamRdEn;
  logic [DW-1:0] ARamRdData = '0;
  logic [AW+1:0] ACount;
  logic          AOvf;

  int nCmp = 0;
  int nBad = 0;

  ram_fifo_ctrl #(.CAddrLen(AW), .CDataLen(DW)) dut (
    .AClkH(AClkH), .AResetH(AResetH), .AClkHEn(AClkHEn),
    .AWrData(AWrData), .AWrStrobe(AWrStrobe), .AFull(AFull),
    .ARdData(ARdData), .ARdValid(ARdValid), .ARdAck(ARdAck),
    .ARamWrAddr(ARamWrAddr), .ARamWrData(ARamWrData), .ARamWrEn(ARamWrEn),
    .ARamRdAddr(ARamRdAddr), .ARamRdEn(ARamRdEn), .ARamRdData(ARamRdData),
    .ACount(ACount), .AOvf(AOvf)
  );

  always #5 AClkH = ~AClkH;

  // Dual-port RAM: registered read, result zero when no read was enabled.
  logic [DW-1:0] ram [1 << AW];
  always @(posedge AClkH) begin
    if (AClkHEn) begin
      if (ARamWrEn) ram[ARamWrAddr] <= ARamWrData;
      ARamRdData <= ARamRdEn ? ram[ARamRdAddr] : '0;
    end
  end

  // Reference model: ordered contents of the block plus sticky overflow.
  logic [DW-1:0] q[$];
  logic          mOvf;

  // Samples of the current cycle, taken at the falling edge.
  logic          sValid, sFull, sOvf, sWrEn, sRdEn;
  logic [DW-1:0] sData, expHead;
  logic [AW+1:0] sCount;
  int            expCount;
  logic          accepted, popped;

  task automatic step(input logic en, input logic wr, input logic [DW-1:0] d, input logic ack);
    AClkHEn = en; AWrStrobe = wr; AWrData = d; ARdAck = ack;
    @(negedge AClkH);
    sValid = ARdValid; sData = ARdData; sCount = ACount; sFull = AFull;
    sOvf = AOvf; sWrEn = ARamWrEn; sRdEn = ARamRdEn;
    expCount = q.size();
    expHead  = (q.size() > 0) ? q[0] : '0;
    accepted = en && wr && !sFull;
    popped   = en && ack && sValid;
    @(posedge AClkH); #1;
    if (accepted) q.push_back(d);
    if (popped) void'(q.pop_front());
    if (en && wr && sFull) mOvf = 1'b1;
  endtask

  task automatic apply_reset(input logic en);
    AResetH = 1'b1; AClkHEn = en; AWrStrobe = 1'b1; ARdAck = 1'b1; AWrData = 16'hDEAD;
    @(negedge AClkH);
    nCmp++;
    if (ARamWrEn !== 1'b0 || ARamRdEn !== 1'b0) begin
      nBad++; $display("FAIL reset_strobes: got wr=%b rd=%b required 0/0", ARamWrEn, ARamRdEn);
    end
    @(posedge AClkH); #1;
    AResetH = 1'b0; AWrStrobe = 1'b0; ARdAck = 1'b0;
    q.delete();
    mOvf = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset(1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    nCmp++;
    if ({sValid, sFull, sOvf} !== 3'b000) begin
      nBad++; $display("FAIL reset_flags: got valid/full/ovf=%b required 000", {sValid, sFull, sOvf});
    end
    nCmp++;
    if (sCount !== '0) begin nBad++; $display("FAIL reset_count: got %0d required 0", sCount); end
    nCmp++;
    if (sData !== '0) begin nBad++; $display("FAIL reset_rddata: got %h required 0000", sData); end
  endtask

  task automatic test_single;
    step(1'b1, 1'b1, 16'h1234, 1'b0);
    nCmp++;
    if (sWrEn !== 1'b1) begin nBad++; $display("FAIL single_wren: got %b required 1", sWrEn); end
    step(1'b1, 1'b0, '0, 1'b0);
    nCmp++;
    if (sCount !== 10'd1 || sValid !== 1'b0) begin
      nBad++; $display("FAIL single_c1: got count=%0d valid=%b required 1/0", sCount, sValid);
    end
    step(1'b1, 1'b0, '0, 1'b0);
    nCmp++;
    if (sValid !== 1'b0) begin nBad++; $display("FAIL single_c2_valid: got %b required 0", sValid); end
    step(1'b1, 1'b0, '0, 1'b1);
    nCmp++;
    if (sValid !== 1'b1 || sData !== 16'h1234) begin
      nBad++; $display("FAIL single_c3: got valid=%b data=%h required 1/1234", sValid, sData);
    end
    step(1'b1, 1'b0, '0, 1'b0);
    nCmp++;
    if (sCount !== '0 || sValid !== 1'b0) begin
      nBad++; $display("FAIL single_after_ack: got count=%0d valid=%b required 0/0", sCount, sValid);
    end
  endtask

  task automatic test_fill;
    int acc = 0;
    int nextExp = 0;
    int budget = 0;
    apply_reset(1'b1);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b1, DW'(i), 1'b0);
      if (accepted) acc++;
    end
    nCmp++;
    if (acc != 258) begin nBad++; $display("FAIL fill_accepted: got %0d required 258", acc); end
    step(1'b1, 1'b0, '0, 1'b0);
    nCmp++;
    if (sFull !== 1'b1 || sOvf !== 1'b1) begin
      nBad++; $display("FAIL fill_flags: got full=%b ovf=%b required 1/1", sFull, sOvf);
    end
    nCmp++;
    if (sCount !== 10'd258) begin nBad++; $display("FAIL fill_count: got %0d required 258", sCount); end
    while (q.size() > 0 && budget < 600) begin
      step(1'b1, 1'b0, '0, 1'b1);
      budget++;
      nCmp++;
      if (sCount !== AW'(0) + 10'(expCount)) begin
        nBad++; $display("FAIL fill_drain_count: got %0d required %0d", sCount, expCount);
      end
      if (popped) begin
        nCmp++;
        if (sData !== DW'(nextExp)) begin
          nBad++; $display("FAIL fill_drain_data: got %h required %h", sData, DW'(nextExp));
        end
        nextExp++;
      end
    end
    nCmp++;
    if (nextExp != 258) begin nBad++; $display("FAIL fill_drained: got %0d words required 258", nextExp); end
    step(1'b1, 1'b0, '0, 1'b0);
    nCmp++;
    if (sCount !== '0 || sFull !== 1'b0 || sValid !== 1'b0 || sOvf !== 1'b1) begin
      nBad++; $display("FAIL fill_empty: got count=%0d full=%b valid=%b ovf=%b required 0/0/0/1",
                       sCount, sFull, sValid, sOvf);
    end
  endtask

  task automatic test_midreset;
    nCmp++;
    if (AOvf !== 1'b1) begin nBad++; $display("FAIL midrst_pre_ovf: got %b required 1", AOvf); end
    step(1'b1, 1'b1, 16'h5555, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    nCmp++;
    if (sRdEn !== 1'b1) begin nBad++; $display("FAIL midrst_issue: got %b required 1", sRdEn); end
    apply_reset(1'b1);
    step(1'b1, 1'b0, '0, 1'b0);
    nCmp++;
    if (sCount !== '0 || sValid !== 1'b0 || sOvf !== 1'b0) begin
      nBad++; $display("FAIL midrst_after: got count=%0d valid=%b ovf=%b required 0/0/0", sCount, sValid, sOvf);
    end
    step(1'b1, 1'b1, 16'hBEEF, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    nCmp++;
    if (sValid !== 1'b0 || sCount !== 10'd1) begin
      nBad++; $display("FAIL midrst_stale: got valid=%b count=%0d required 0/1", sValid, sCount);
    end
    step(1'b1, 1'b0, '0, 1'b1);
    nCmp++;
    if (sValid !== 1'b1 || sData !== 16'hBEEF) begin
      nBad++; $display("FAIL midrst_beef: got valid=%b data=%h required 1/beef", sValid, sData);
    end
  endtask

  task automatic test_stream;
    int pushed = 0;
    int budget = 0;
    logic seen = 1'b0;
    apply_reset(1'b1);
    while (pushed < 1000) begin
      step(1'b1, 1'b1, DW'($urandom), 1'b1);
      if (accepted) pushed++;
      if (seen) begin
        nCmp++;
        if (sValid !== 1'b1 || sCount !== 10'd3) begin
          nBad++; $display("FAIL stream_steady: got valid=%b count=%0d required 1/3", sValid, sCount);
        end
      end
      if (popped) begin
        seen = 1'b1;
        nCmp++;
        if (sData !== expHead) begin
          nBad++; $display("FAIL stream_data: got %h required %h", sData, expHead);
        end
      end
    end
    while (q.size() > 0 && budget < 20) begin
      step(1'b1, 1'b0, '0, 1'b1);
      budget++;
      if (popped) begin
        nCmp++;
        if (sData !== expHead) begin nBad++; $display("FAIL stream_tail: got %h required %h", sData, expHead); end
      end
    end
    step(1'b1, 1'b0, '0, 1'b0);
    nCmp++;
    if (sCount !== '0) begin nBad++; $display("FAIL stream_final: got %0d required 0", sCount); end
  endtask

  task automatic test_wrap;
    apply_reset(1'b1);
    for (int r = 0; r < 5; r++) begin
      int pops = 0;
      int budget = 0;
      for (int i = 0; i < 200; i++) step(1'b1, 1'b1, DW'($urandom), 1'b0);
      while (pops < 200 && budget < 400) begin
        step(1'b1, 1'b0, '0, 1'b1);
        budget++;
        if (popped) begin
          pops++;
          nCmp++;
          if (sData !== expHead) begin nBad++; $display("FAIL wrap_data: got %h required %h", sData, expHead); end
        end
      end
      nCmp++;
      if (pops != 200) begin nBad++; $display("FAIL wrap_pops: got %0d required 200", pops); end
    end
    step(1'b1, 1'b0, '0, 1'b0);
    nCmp++;
    if (sCount !== '0) begin nBad++; $display("FAIL wrap_final: got %0d required 0", sCount); end
  endtask

  task automatic test_clken;
    logic          pEn = 1'b1;
    logic          pValid;
    logic [DW-1:0] pData;
    logic [AW+1:0] pCount;
    int            budget = 0;
    apply_reset(1'b1);
    for (int i = 0; i < 600; i++) begin
      logic en;
      en = ($urandom_range(0, 1) == 1);
      step(en, $urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 3) != 0);
      nCmp++;
      if (sCount !== 10'(expCount)) begin
        nBad++; $display("FAIL clken_count: got %0d required %0d", sCount, expCount);
      end
      if (!en) begin
        nCmp++;
        if (sWrEn !== 1'b0 || sRdEn !== 1'b0) begin
          nBad++; $display("FAIL clken_strobes: got wr=%b rd=%b required 0/0", sWrEn, sRdEn);
        end
      end
      if (!pEn) begin
        nCmp++;
        if (sValid !== pValid || sData !== pData || sCount !== pCount) begin
          nBad++; $display("FAIL clken_hold: got %b/%h/%0d required %b/%h/%0d",
                           sValid, sData, sCount, pValid, pData, pCount);
        end
      end
      if (popped) begin
        nCmp++;
        if (sData !== expHead) begin nBad++; $display("FAIL clken_data: got %h required %h", sData, expHead); end
      end
      pEn = en; pValid = sValid; pData = sData; pCount = sCount;
    end
    while (q.size() > 0 && budget < 300) begin
      step(1'b1, 1'b0, '0, 1'b1);
      budget++;
      if (popped) begin
        nCmp++;
        if (sData !== expHead) begin nBad++; $display("FAIL clken_drain: got %h required %h", sData, expHead); end
      end
    end
    nCmp++;
    if (q.size() != 0) begin nBad++; $display("FAIL clken_drain_left: got %0d words required 0", q.size()); end
  endtask

  initial begin
    mOvf = 1'b0;
    @(posedge AClkH); #1;
    test_reset();
    test_single();
    test_fill();
    test_midreset();
    test_stream();
    test_wrap();
    test_clken();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
